// File: rtl/mult_cdb_buffer.sv
// mult_cdb_buffer: in-order completion FIFO from two multiplier lanes onto two CDB slots with RS issue credits; define MULT_CDB_BYPASS_EN to let results skip an empty FIFO
module mult_cdb_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  rs_issue,
  input  logic        mul_complete0,
  input  logic        mul_complete1,
  input  logic [4:0]  mul_dest_ar_idx0,
  input  logic [4:0]  mul_dest_ar_idx1,
  input  logic [6:0]  mul_dest_pr_idx0,
  input  logic [6:0]  mul_dest_pr_idx1,
  input  logic [63:0] mul_result0,
  input  logic [63:0] mul_result1,
  input  logic [1:0]  cdb_grant,
  output logic [1:0]  cdb_req,
  output logic        cdb_complete0,
  output logic        cdb_complete1,
  output logic [4:0]  cdb_dest_ar_idx0,
  output logic [4:0]  cdb_dest_ar_idx1,
  output logic [6:0]  cdb_prf_dest_pr_idx0,
  output logic [6:0]  cdb_prf_dest_pr_idx1,
  output logic [63:0] prf_result0,
  output logic [63:0] prf_result1,
  output logic        prf_write_enable0,
  output logic        prf_write_enable1,
  output logic [1:0]  rs_mult_avail,
  output logic        overflow_err
);
  typedef struct packed {
    logic [4:0]  ar;
    logic [6:0]  pr;
    logic [63:0] res;
  } entry_t;
  localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W+2)'(DEPTH);
  entry_t mem [DEPTH];
  entry_t in0, in1, inc_a, slot0, slot1, push_a;
  logic [PTR_W-1:0] head, tail, head1, tail1;
  logic [PTR_W:0] count, inflight, avail;
  logic [PTR_W+1:0] room, used;
  logic [1:0] inc_n, iss_n, pops, fpop, push_n, accept;
  logic byp, pop0, pop1, ovf;
  // slot selection, pop/push arbitration, credits and CDB drive
  always_comb begin
    in0 = {mul_dest_ar_idx0, mul_dest_pr_idx0, mul_result0};
    in1 = {mul_dest_ar_idx1, mul_dest_pr_idx1, mul_result1};
    inc_n = 2'(mul_complete0) + 2'(mul_complete1);
    iss_n = 2'(rs_issue[0]) + 2'(rs_issue[1]);
    inc_a = mul_complete0 ? in0 : in1;
`ifdef MULT_CDB_BYPASS_EN
    byp = count == '0;
`else
    byp = 1'b0;
`endif
    head1 = head + PTR_W'(1);
    tail1 = tail + PTR_W'(1);
    slot0 = byp ? inc_a : mem[head];
    slot1 = byp ? in1 : mem[head1];
    avail = byp ? (PTR_W+1)'(inc_n) : count;
    cdb_req = {avail >= (PTR_W+1)'(2), avail != '0};
    pop0 = cdb_grant[0] & cdb_req[0];
    pop1 = pop0 & cdb_grant[1] & cdb_req[1];
    pops = 2'(pop0) + 2'(pop1);
    fpop = byp ? 2'd0 : pops;
    push_n = byp ? inc_n - pops : inc_n;
    push_a = (byp && pop0) ? in1 : inc_a;
    room = DEPTH_W - (PTR_W+2)'(count) + (PTR_W+2)'(fpop);
    ovf = (PTR_W+2)'(push_n) > room;
    accept = ovf ? room[1:0] : push_n;
    used = (PTR_W+2)'(count) + (PTR_W+2)'(inflight);
    rs_mult_avail = (used + (PTR_W+2)'(2) <= DEPTH_W) ? 2'b11 :
                    (used + (PTR_W+2)'(1) == DEPTH_W) ? 2'b01 : 2'b00;
    cdb_complete0 = pop0;
    cdb_complete1 = pop1;
    cdb_dest_ar_idx0 = pop0 ? slot0.ar : '0;
    cdb_dest_ar_idx1 = pop1 ? slot1.ar : '0;
    cdb_prf_dest_pr_idx0 = pop0 ? slot0.pr : '0;
    cdb_prf_dest_pr_idx1 = pop1 ? slot1.pr : '0;
    prf_result0 = pop0 ? slot0.res : '0;
    prf_result1 = pop1 ? slot1.res : '0;
    prf_write_enable0 = pop0 && slot0.ar != 5'd31;
    prf_write_enable1 = pop1 && slot1.ar != 5'd31;
  end
  // pointers, occupancy, in-flight count and sticky overflow flag
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      inflight <= '0;
      overflow_err <= 1'b0;
    end else begin
      head <= head + PTR_W'(fpop);
      tail <= tail + PTR_W'(accept);
      count <= count + (PTR_W+1)'(accept) - (PTR_W+1)'(fpop);
      inflight <= inflight + (PTR_W+1)'(iss_n) - (PTR_W+1)'(inc_n);
      overflow_err <= overflow_err | ovf;
    end
  end
  // entry storage, lane0 result written ahead of lane1
  always_ff @(posedge clock) begin
    if (accept != 2'd0) mem[tail] <= push_a;
    if (accept == 2'd2) mem[tail1] <= in1;
  end
endmodule

// File: doc/mult_cdb_buffer.md
# mult_cdb_buffer

Completion buffer between the two pipelined multiplier lanes and the common data bus (CDB). The multiplier lanes cannot stall, so every result they produce is captured in an in-order FIFO. Results drain onto two CDB slots under arbiter grant. The block also returns issue credits to the multiply reservation station, so that no result ever arrives without a free entry.

## Interface
- DEPTH, 8: FIFO entries; power of two, ≥4
- PTR_W, 3: log2(DEPTH)
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- rs_issue  in  2  per-lane multiply issued into the multiplier this cycle (bit0 lane0, bit1 lane1)
- mul_complete0/1  in  1  multiplier lane result valid
- mul_dest_ar_idx0/1  in  5  architectural destination
- mul_dest_pr_idx0/1  in  7  physical destination
- mul_result0/1  in  64  product (low 64 bits)
- cdb_grant  in  2  arbiter grant for CDB slot0/slot1
- cdb_req  out  2  entries available for slot0/slot1
- cdb_complete0/1  out  1  slot broadcast valid
- cdb_dest_ar_idx0/1  out  5  
- cdb_prf_dest_pr_idx0/1  out  7  
- prf_result0/1  out  64  
- prf_write_enable0/1  out  1  
- rs_mult_avail  out  2  issue credits to the RS
- overflow_err  out  1  sticky; a result arrived with no free entry

## Operation
- FIFO state: head, tail (PTR_W bits, wrap modulo DEPTH), count (PTR_W+1 bits), inflight (PTR_W+1 bits).
- Push order each cycle: lane0 result before lane1 result. Zero, one, or two pushes per cycle; tail advances by the number of pushes.
- Pop rules:
  - cdb_req[0] = count≥1; cdb_req[1] = count≥2.
  - Slot0 carries the head entry; slot1 carries head+1.
  - A grant pops an entry only if the matching req bit is set.
  - Slot1 pops only together with slot0. grant=2'b10 is treated as 2'b00.
- cdb_completeN = effective grant bit. cdb fields come from the entry; they are 0 when not complete.
- prf_write_enableN = cdb_completeN && dest_ar_idx ≠ 5'd31. A zero-register destination still completes to the ROB but does not write the PRF.
- count_next = count + pushes − pops.
- inflight_next = inflight + popcount(rs_issue) − popcount(mul_complete).
- Credits: free = DEPTH − count − inflight, evaluated on registered values.
  - rs_mult_avail = 2'b11 if free≥2, 2'b01 if free==1, 2'b00 if free==0.
- Overflow: a push while count==DEPTH (after same-cycle pops) is dropped and sets overflow_err. overflow_err clears only on reset.
- Simultaneous push and pop when full: pops are applied first, so the pushes are accepted.

## Timing
- Reset values: all outputs 0 except rs_mult_avail = 2'b11. head, tail, count, inflight, overflow_err all 0.
- Reset mid-operation: all entries and the inflight count are discarded. Results still in the multiplier pipe after reset are ignored, because the mult lanes' own done chain is reset.
- Multiplier latency: rs_issue at cycle T gives mul_complete at cycle T+5 (1 operand-register stage + 4 mult stages).
- Push at cycle T becomes visible on cdb_req at T+1 (without bypass).
- CDB outputs are combinational from registered FIFO state and cdb_grant. The pop takes effect at the clock edge.
- Credits update one cycle after issue. The RS must not issue more lanes than rs_mult_avail advertises.

## Configuration
- MULT_CDB_BYPASS_EN defined:
  - When count==0 and the incoming mul_complete0 (and 1) are granted, the result drives the CDB in the same cycle and is not written into the FIFO.
  - Bypassed entries still decrement inflight.
  - Without bypass, the minimum residency is 1 cycle.
- MULT_CDB_BYPASS_EN undefined: every result passes through the FIFO.

## Test plan
- Reset, then idle: rs_mult_avail=2'b11, cdb_req=0, all CDB outputs 0.
- Issue both lanes at T, grant 2'b11 held:
  - Without bypass: both results appear on cdb_complete0/1 at T+6 with the correct pr_idx and products (e.g. 3×5=15, 0xFFFF_FFFF×2=0x1_FFFF_FFFE).
  - With bypass: they appear at T+5.
- Grant held at 0 while issuing 2 per cycle:
  - rs_mult_avail reaches 2'b00 once count+inflight=8.
  - No overflow_err.
  - Then grant=2'b01 drains one result per cycle in issue order, lane0 before lane1.
- dest_ar_idx=31 result: cdb_complete=1 and prf_write_enable=0.
- grant=2'b10 with count=2: no pop, cdb_complete=0; FIFO contents unchanged on the next cycle.
- Force mul_complete with count=8 and grant 0: overflow_err=1 and stays set; reset mid-stream clears count, inflight, and overflow_err.
